psum_axis_packer: RTL and testbench

Output stage that sits directly downstream of the MAC data path. It captures each wide partial-sum vector (`MAC_NUM` × 5-bit psums) presented with a single-cycle `psum_valid` strobe and buffers up to two vectors, because the producer has no backpressure. It serialises each vector into 32-bit AXI4-Stream master beats, asserting TLAST on the last beat of every frame of `frame_len` vectors.

---
 rtl/psum_axis_packer_if.sv | 14 +
 rtl/psum_axis_packer.sv | 135 +++++++++++++
 tb/tb_psum_axis_packer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_axis_packer_if.sv
// AXI4-Stream beat bus for the psum packer output.
// The master modport drives data/valid/last; the slave modport drives ready.
interface psum_axis_packer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      TVALID;
  logic [DATA_WIDTH-1:0]     TDATA;
  logic [DATA_WIDTH/8-1:0]   TSTRB;
  logic                      TLAST;
  logic                      TREADY;

  modport master (output TVALID, TDATA, TSTRB, TLAST, input TREADY);
  modport slave  (input TVALID, TDATA, TSTRB, TLAST, output TREADY);
endinterface

// File: rtl/psum_axis_packer.sv
// Two-entry psum vector buffer serialised into 32-bit AXI4-Stream beats with per-frame TLAST.
// Define PSUM_PACK_DENSE_EN for six-psums-per-beat packing; default is four 8-bit lanes per beat.
module psum_axis_packer #(
  parameter int MAC_NUM              = 256,
  parameter int PSUM_WIDTH           = 5,
  parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PSUM_WIDTH*MAC_NUM-1:0] psum_in,
  input  logic                          psum_valid,
  input  logic [15:0]                   frame_len,
  input  logic                          stat_clear,
  psum_axis_packer_if.master            M_AXIS,
  output logic [1:0]                    buf_level,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);

`ifdef PSUM_PACK_DENSE_EN
  localparam int LANES  = 6;
  localparam int LANE_W = PSUM_WIDTH;
`else
  localparam int LANES  = 4;
  localparam int LANE_W = 8;
`endif
  localparam int BEATS  = (MAC_NUM + LANES - 1) / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VEC_W  = PSUM_WIDTH * MAC_NUM;
  localparam int IDX_W  = $clog2(VEC_W);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                          state, state_nxt;
  logic [VEC_W-1:0]                vec_buf [2];
  logic [VEC_W-1:0]                head;
  logic                            wr_ptr, rd_ptr;
  logic [1:0]                      level;
  logic [BEAT_W-1:0]               beat;
  logic [15:0]                     vec_cnt, frame_len_q;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] beat_data;
  logic [IDX_W-1:0]                psum_base;
  logic                            hs, last_beat, frame_end;
  logic                            release_head, drop, capture;

  assign last_beat    = (beat == BEAT_W'(BEATS - 1));
  assign frame_end    = (vec_cnt == frame_len_q - 16'd1);
  assign hs           = M_AXIS.TVALID && M_AXIS.TREADY;
  assign release_head = hs && last_beat;
  // A full buffer still accepts a vector when the head frees its slot on the same edge.
  assign drop         = psum_valid && (level == 2'd2) && !release_head;
  assign capture      = psum_valid && !drop;
  assign buf_level    = level;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Entering STREAM on the capture edge gives TVALID one cycle after the strobe.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (capture) state_nxt = S_STREAM;
      S_STREAM: if (release_head && (level == 2'd1) && !capture) state_nxt = S_IDLE;
    endcase
  end

  // Outputs derive only from registered state, so they hold steady through a stall.
  always_comb begin
    M_AXIS.TVALID = (state == S_STREAM);
    M_AXIS.TLAST  = M_AXIS.TVALID && last_beat && frame_end;
    M_AXIS.TDATA  = M_AXIS.TVALID ? beat_data : '0;
    M_AXIS.TSTRB  = '1;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    head      = vec_buf[rd_ptr];
    beat_data = '0;
    psum_base = '0;
    for (int j = 0; j < LANES; j++) begin
      if (int'(beat) * LANES + j < MAC_NUM) begin
        psum_base = IDX_W'((int'(beat) * LANES + j) * PSUM_WIDTH);
        beat_data[j*LANE_W +: PSUM_WIDTH] = head[psum_base +: PSUM_WIDTH];
      end
    end
  end

  // NOTE: the vector store is not reset; pointers and level gate every read of it.
  always_ff @(posedge clk) begin
    if (capture) vec_buf[wr_ptr] <= psum_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      level       <= 2'd0;
      beat        <= '0;
      vec_cnt     <= 16'd0;
      frame_len_q <= 16'd0;
    end else begin
      if (capture)      wr_ptr <= ~wr_ptr;
      if (release_head) rd_ptr <= ~rd_ptr;
      level <= level + {1'b0, capture} - {1'b0, release_head};
      if (capture && (vec_cnt == 16'd0))
        frame_len_q <= (frame_len == 16'd0) ? 16'd1 : frame_len;
      if (hs) begin
        if (last_beat) begin
          beat    <= '0;
          vec_cnt <= frame_end ? 16'd0 : vec_cnt + 16'd1;
        end else begin
          beat <= beat + BEAT_W'(1);
        end
      end
    end
  end

  // A clear coinciding with a drop leaves exactly that one drop recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= 16'd0;
    end else if (stat_clear) begin
      overflow   <= drop;
      drop_count <= {15'd0, drop};
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_psum_axis_packer.sv
// Randomised bench for psum_axis_packer against a queue-based beat/frame reference model.
// Honours PSUM_PACK_DENSE_EN to select the expected packing.
module tb_psum_axis_packer;
  localparam int MAC_NUM    = 256;
  localparam int PSUM_WIDTH = 5;
  localparam int VEC_W      = MAC_NUM * PSUM_WIDTH;
`ifdef PSUM_PACK_DENSE_EN
  localparam int LANES  = 6;
  localparam int LANE_W = 5;
`else
  localparam int LANES  = 4;
  localparam int LANE_W = 8;
`endif
  localparam int BEATS = (MAC_NUM + LANES - 1) / LANES;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [VEC_W-1:0] psum_in = '0;
  logic             psum_valid = 1'b0;
  logic [15:0]      frame_len = 16'd1;
  logic             stat_clear = 1'b0;
  logic [1:0]       buf_level;
  logic             overflow;
  logic [15:0]      drop_count;

  psum_axis_packer_if #(.DATA_WIDTH(32)) axis ();

  psum_axis_packer dut (
    .clk        (clk),
    .rst        (rst),
    .psum_in    (psum_in),
    .psum_valid (psum_valid),
    .frame_len  (frame_len),
    .stat_clear (stat_clear),
    .M_AXIS     (axis),
    .buf_level  (buf_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of expected beats plus held-vector, frame and drop bookkeeping.
  logic [31:0] exp_q [$];
  int          held = 0, b_idx = 0, vc = 0, flq = 0, m_ovf = 0, m_dc = 0, tlast_seen = 0;
  bit          stalled = 0, m_hs, m_rel, m_drop, m_cap, exp_last;
  logic [31:0] prev_data;
  logic        prev_last;

  function automatic void push_vector(input logic [VEC_W-1:0] v);
    logic [31:0] w;
    int          idx;
    for (int k = 0; k < BEATS; k++) begin
      w = 32'd0;
      for (int j = 0; j < LANES; j++) begin
        idx = k * LANES + j;
        if (idx < MAC_NUM) w = w | (32'(v[idx*PSUM_WIDTH +: PSUM_WIDTH]) << (LANE_W * j));
      end
      exp_q.push_back(w);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 0; b_idx = 0; vc = 0; flq = 0; m_ovf = 0; m_dc = 0; stalled = 0;
      check("rst_tvalid", 32'(axis.TVALID), 0);
      check("rst_tdata", axis.TDATA, 0);
      check("rst_tlast", 32'(axis.TLAST), 0);
      check("rst_level", 32'(buf_level), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_drop_count", 32'(drop_count), 0);
    end else begin
      exp_last = (b_idx == BEATS - 1) && (vc == flq - 1);
      check("tvalid", 32'(axis.TVALID), 32'(held != 0));
      check("buf_level", 32'(buf_level), held);
      check("overflow", 32'(overflow), m_ovf);
      check("drop_count", 32'(drop_count), m_dc);
      check("tstrb", 32'(axis.TSTRB), 32'hF);
      if (stalled) begin
        check("hold_tdata", axis.TDATA, prev_data);
        check("hold_tlast", 32'(axis.TLAST), 32'(prev_last));
      end
      if (held != 0) begin
        check("tdata", axis.TDATA, exp_q[0]);
        check("tlast", 32'(axis.TLAST), 32'(exp_last));
      end
      m_hs   = (held != 0) && axis.TREADY;
      m_rel  = m_hs && (b_idx == BEATS - 1);
      m_drop = psum_valid && (held == 2) && !m_rel;
      m_cap  = psum_valid && !m_drop;
      stalled   = (held != 0) && !axis.TREADY;
      prev_data = axis.TDATA;
      prev_last = axis.TLAST;
      if (m_hs && axis.TLAST) tlast_seen++;
      if (m_cap) begin
        if (vc == 0) flq = (frame_len == 16'd0) ? 1 : int'(frame_len);
        push_vector(psum_in);
      end
      if (m_hs) begin
        void'(exp_q.pop_front());
        if (m_rel) begin
          b_idx = 0;
          vc    = exp_last ? 0 : vc + 1;
        end else begin
          b_idx++;
        end
      end
      held = held + int'(m_cap) - int'(m_rel);
      if (stat_clear) begin
        m_ovf = int'(m_drop);
        m_dc  = int'(m_drop);
      end else if (m_drop) begin
        m_ovf = 1;
        if (m_dc < 65535) m_dc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < MAC_NUM; i++) v[i*PSUM_WIDTH +: PSUM_WIDTH] = PSUM_WIDTH'($urandom);
    return v;
  endfunction

  function automatic logic [VEC_W-1:0] ramp_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < MAC_NUM; i++) v[i*PSUM_WIDTH +: PSUM_WIDTH] = PSUM_WIDTH'(i % 32);
    return v;
  endfunction

  task automatic send(input logic [VEC_W-1:0] v);
    psum_in    = v;
    psum_valid = 1'b1;
    tick();
    psum_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (held != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", held, 0);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    axis.TREADY = 1'b0;
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single ramp vector: beat 0 visible one cycle after the strobe, one TLAST.
    axis.TREADY = 1'b1;
    tlast_seen  = 0;
    send(ramp_vec());
    check("first_tvalid", 32'(axis.TVALID), 1);
`ifdef PSUM_PACK_DENSE_EN
    check("first_tdata", axis.TDATA, {2'b0, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0});
`else
    check("first_tdata", axis.TDATA, 32'h03020100);
`endif
    drain(4 * BEATS);
    check("single_tlasts", tlast_seen, 1);

    // Alternating backpressure.
    axis.TREADY = 1'b0;
    send(rand_vec());
    for (int c = 0; c < 4 * BEATS && held != 0; c++) begin
      axis.TREADY = ~axis.TREADY;
      tick();
    end
    axis.TREADY = 1'b1;
    drain(4 * BEATS);

    // Overflow, then clear coinciding with a drop, then a plain clear.
    axis.TREADY = 1'b0;
    send(rand_vec());
    send(rand_vec());
    send(rand_vec());
    check("ovf_level", 32'(buf_level), 2);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_drops", 32'(drop_count), 1);
    send(rand_vec());
    send(rand_vec());
    stat_clear = 1'b1;
    send(rand_vec());
    stat_clear = 1'b0;
    check("clr_drop_flag", 32'(overflow), 1);
    check("clr_drop_count", 32'(drop_count), 1);
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    check("clr_flag", 32'(overflow), 0);
    check("clr_count", 32'(drop_count), 0);
    axis.TREADY = 1'b1;
    drain(8 * BEATS);

    // Free-and-capture: strobe lands on the head's final handshake with level 2.
    axis.TREADY = 1'b0;
    send(rand_vec());
    send(rand_vec());
    axis.TREADY = 1'b1;
    repeat (BEATS - 1) tick();
    send(rand_vec());
    check("fac_level", 32'(buf_level), 2);
    check("fac_drops", 32'(drop_count), 0);
    check("fac_flag", 32'(overflow), 0);
    drain(8 * BEATS);

    // Framing: three-vector frame, then frame_len 0 acts as 1.
    frame_len  = 16'd3;
    tlast_seen = 0;
    for (int n = 0; n < 5; n++) begin
      if (n == 3) frame_len = 16'd0;
      send(rand_vec());
      drain(4 * BEATS);
    end
    check("frame_tlasts", tlast_seen, 3);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      psum_valid = ($urandom_range(0, 99) < 3);
      if (psum_valid) psum_in = rand_vec();
      axis.TREADY = ($urandom_range(0, 3) != 0);
      stat_clear  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) == 0) frame_len = 16'($urandom_range(0, 4));
      tick();
    end
    psum_valid  = 1'b0;
    stat_clear  = 1'b0;
    axis.TREADY = 1'b1;
    drain(8 * BEATS);

    // Reset mid-vector discards everything; streaming resumes cleanly afterwards.
    frame_len = 16'd2;
    send(rand_vec());
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("midrst_tvalid", 32'(axis.TVALID), 0);
    check("midrst_level", 32'(buf_level), 0);
    rst = 1'b0;
    tick();
    frame_len  = 16'd1;
    tlast_seen = 0;
    send(ramp_vec());
    drain(4 * BEATS);
    check("post_rst_tlasts", tlast_seen, 1);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
